// File: rtl/multicycle_control.sv
// Multicycle control unit: FETCH/DECODE/EXEC/WB sequencer with registered decode,
// flag latching for branches, sticky illegal-opcode flag and retired-instruction counter.
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flag_zero,
    input  logic                flag_neg,
    input  logic                stall,
    output logic                ir_load,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                we,
    output logic                pc_en,
    output logic [1:0]          pc_sel,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {K_SEQ, K_BEQ, K_BNE, K_BGE, K_BLT, K_JMP, K_JMPR} kind_t;

    state_t state, state_nx;

    logic [OPCODE_W-1:0] ir;
    logic [ALU_OP_W-1:0] alu_op_r;
    logic                we_r;
    kind_t               kind_r;
    logic                fz_r, fn_r;

    logic [ALU_OP_W-1:0] dec_alu;
    logic                dec_we, dec_ill, dec_halt;
    kind_t               dec_kind;

    // Opcodes with any bit above bit 3 set never match a defined instruction.
    always_comb begin
        dec_alu  = '0;
        dec_we   = 1'b0;
        dec_ill  = 1'b0;
        dec_halt = 1'b0;
        dec_kind = K_SEQ;
        if ((ir >> 4) != '0) begin
            dec_ill = 1'b1;
        end else begin
            case (ir[3:0])
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                    dec_alu = ALU_OP_W'(ir[3:0]);
                    dec_we  = 1'b1;
                end
                4'd5:  dec_kind = K_BEQ;
                4'd6:  dec_kind = K_BNE;
                4'd7:  dec_kind = K_BGE;
                4'd9:  dec_kind = K_BLT;
                4'd11: begin dec_kind = K_JMP;  dec_we = 1'b1; end
                4'd12: begin dec_kind = K_JMPR; dec_we = 1'b1; end
                4'd15: dec_halt = 1'b1;
                default: dec_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (imem_ack) state_nx = S_DECODE;
            S_DECODE: state_nx = dec_halt ? S_HALT : S_EXEC;
            S_EXEC:   if (!stall) state_nx = S_WB;
            S_WB:     if (!stall) state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir          <= '0;
            alu_op_r    <= '0;
            we_r        <= 1'b0;
            kind_r      <= K_SEQ;
            fz_r        <= 1'b0;
            fn_r        <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (state == S_FETCH && imem_ack)
                ir <= opcode;
            if (state == S_DECODE && !dec_halt) begin
                alu_op_r <= dec_alu;
                we_r     <= dec_we;
                kind_r   <= dec_kind;
                if (dec_ill) illegal <= 1'b1;
            end
            // Last EXEC cycle samples flags, so a stall simply defers the sample.
            if (state == S_EXEC && !stall) begin
                fz_r <= flag_zero;
                fn_r <= flag_neg;
            end
            if ((state == S_WB && !stall) || (state == S_DECODE && dec_halt))
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // imem_req is gated by rst_n so nothing requests a fetch while reset is held.
    always_comb begin
        imem_req = rst_n && (state == S_FETCH);
        ir_load  = imem_req && imem_ack;
        halted   = (state == S_HALT);
        alu_op   = (state == S_EXEC || state == S_WB) ? alu_op_r : '0;
        pc_en    = (state == S_WB) && !stall;
        we       = pc_en && we_r;
        pc_sel   = 2'd0;
        if (state == S_WB) begin
            case (kind_r)
                K_BEQ:   pc_sel = {1'b0, fz_r};
                K_BNE:   pc_sel = {1'b0, !fz_r};
                K_BGE:   pc_sel = {1'b0, !fn_r};
                K_BLT:   pc_sel = {1'b0, fn_r};
                K_JMP:   pc_sel = 2'd2;
                K_JMPR:  pc_sel = 2'd3;
                default: pc_sel = 2'd0;
            endcase
        end
    end

endmodule
